preset_sequencer: RTL and testbench

//  Sequences the plotter datapath through the segments of a preset shape (square, triangle, star).

---
 rtl/preset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_preset_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/preset_sequencer.sv
// Preset shape sequencer: arbitrates preset requests and walks the segment table of the
// chosen shape, issuing one relative move per segment over a valid/ready handshake.
module preset_sequencer #(
  parameter int W    = 16,
  parameter int SIDE = 400
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_square,
  input  logic         req_tri,
  input  logic         req_star,
  input  logic         abort,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [W-1:0] cmd_dx,
  output logic [W-1:0] cmd_dy,
  input  logic         seg_done,
  output logic         pen_down,
  output logic         busy,
  output logic [1:0]   shape_id,
  output logic         shape_done
);

  typedef enum logic [2:0] {
    IDLE,
    PEN,
    ISSUE,
    WAIT,
    LIFT
  } state_t;

  localparam logic [W-1:0] S = W'(SIDE);
  localparam logic [W-1:0] H = W'(SIDE / 2);

  state_t      state_q, state_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  seg_q, seg_d;
  logic [1:0]  shape_q, shape_d;
  logic        pen_q, pen_d;
  logic [2:0]  win;
  logic [2:0]  last_seg;
  logic [W-1:0] seg_dx, seg_dy;

  // Segment table, indexed by active shape and segment number.
  always_comb begin
    seg_dx   = '0;
    seg_dy   = '0;
    last_seg = '0;
    case (shape_q)
      2'd1: begin
        last_seg = 3'd3;
        case (seg_q)
          3'd0:    begin seg_dx = S;  seg_dy = '0; end
          3'd1:    begin seg_dx = '0; seg_dy = S;  end
          3'd2:    begin seg_dx = -S; seg_dy = '0; end
          3'd3:    begin seg_dx = '0; seg_dy = -S; end
          default: ;
        endcase
      end
      2'd2: begin
        last_seg = 3'd2;
        case (seg_q)
          3'd0:    begin seg_dx = S;  seg_dy = '0; end
          3'd1:    begin seg_dx = -H; seg_dy = S;  end
          3'd2:    begin seg_dx = -H; seg_dy = -S; end
          default: ;
        endcase
      end
      2'd3: begin
        last_seg = 3'd4;
        case (seg_q)
          3'd0:    begin seg_dx = H;  seg_dy = S;  end
          3'd1:    begin seg_dx = H;  seg_dy = -S; end
          3'd2:    begin seg_dx = -S; seg_dy = H;  end
          3'd3:    begin seg_dx = S;  seg_dy = '0; end
          3'd4:    begin seg_dx = -S; seg_dy = -H; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    shape_d    = shape_q;
    pen_d      = pen_q;
    shape_done = 1'b0;
    win        = '0;

    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          if (pending_q[0]) begin
            win     = 3'b001;
            shape_d = 2'd1;
          end else if (pending_q[1]) begin
            win     = 3'b010;
            shape_d = 2'd2;
          end else begin
            win     = 3'b100;
            shape_d = 2'd3;
          end
          state_d = PEN;
        end
      end
      PEN: begin
        pen_d   = 1'b1;
        seg_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_ready) state_d = WAIT;
      end
      WAIT: begin
        if (seg_done) begin
          if (seg_q == last_seg) begin
            state_d = LIFT;
          end else begin
            seg_d   = seg_q + 3'd1;
            state_d = ISSUE;
          end
        end
      end
      LIFT: begin
        pen_d      = 1'b0;
        shape_done = 1'b1;
        shape_d    = '0;
        seg_d      = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request pulse is absorbed into pending even while busy; abort wipes everything,
    // including a request arriving in the same cycle.
    pending_d = (pending_q & ~win) | {req_star, req_tri, req_square};
    if (abort) begin
      state_d    = IDLE;
      pending_d  = '0;
      seg_d      = '0;
      shape_d    = '0;
      pen_d      = 1'b0;
      shape_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      seg_q     <= '0;
      shape_q   <= '0;
      pen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      shape_q   <= shape_d;
      pen_q     <= pen_d;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_dx    = cmd_valid ? seg_dx : '0;
  assign cmd_dy    = cmd_valid ? seg_dy : '0;
  assign busy      = (state_q != IDLE);
  assign pen_down  = pen_q;
  assign shape_id  = shape_q;

endmodule

// File: tb/tb_preset_sequencer.sv
// Bench for preset_sequencer: cycle-accurate vector table plus directed multi-cycle sequences
// against a small datapath responder that answers each accepted move with seg_done.
module tb_preset_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_square, req_tri, req_star, abort;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_dx, cmd_dy;
  logic        seg_done, pen_down, busy, shape_done;
  logic [1:0]  shape_id;

  logic tb_ready, tb_sd, auto_dp, dp_done;
  int   dp_cnt;

  assign cmd_ready = tb_ready;
  assign seg_done  = auto_dp ? dp_done : tb_sd;

  preset_sequencer #(.W(16), .SIDE(400)) dut (
    .clk(clk), .reset(reset),
    .req_square(req_square), .req_tri(req_tri), .req_star(req_star), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dx(cmd_dx), .cmd_dy(cmd_dy),
    .seg_done(seg_done), .pen_down(pen_down), .busy(busy),
    .shape_id(shape_id), .shape_done(shape_done)
  );

  always #5 clk = ~clk;

  typedef struct { int dx; int dy; int id; int pen; } mv_t;
  mv_t got[$];
  mv_t expq[$];
  int  done_cnt = 0;

  // Move log and datapath responder: seg_done follows each accepted move a few cycles later.
  initial begin
    dp_done = 1'b0;
    dp_cnt  = 0;
  end
  always @(negedge clk) begin
    dp_done = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 1) dp_done = 1'b1;
    end
    if (cmd_valid && cmd_ready) begin
      got.push_back('{int'($signed(cmd_dx)), int'($signed(cmd_dy)), int'(shape_id), int'(pen_down)});
      dp_cnt = 3;
    end
    if (shape_done) done_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic sq, input logic tr, input logic st);
    req_square = sq; req_tri = tr; req_star = st;
    tick();
    req_square = 1'b0; req_tri = 1'b0; req_star = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int max);
    int q = 0;
    int n = 0;
    while (q < 3 && n < max) begin
      tick();
      n++;
      q = busy ? 0 : q + 1;
    end
    chk({name, "_reach_idle"}, int'(q >= 3), 1);
  endtask

  task automatic wait_hs(input string name, input int target, input int max);
    int n = 0;
    while (got.size() < target && n < max) begin
      tick();
      n++;
    end
    chk({name, "_hs_seen"}, int'(got.size() >= target), 1);
  endtask

  task automatic add(input int dx, input int dy, input int id);
    expq.push_back('{dx, dy, id, 1});
  endtask

  task automatic compare_log(input string name, input int base);
    int n = got.size() - base;
    chk({name, "_moves"}, n, expq.size());
    for (int i = 0; i < expq.size() && i < n; i++) begin
      chk($sformatf("%s_dx%0d", name, i),  got[base+i].dx,  expq[i].dx);
      chk($sformatf("%s_dy%0d", name, i),  got[base+i].dy,  expq[i].dy);
      chk($sformatf("%s_id%0d", name, i),  got[base+i].id,  expq[i].id);
      chk($sformatf("%s_pen%0d", name, i), got[base+i].pen, expq[i].pen);
    end
    expq.delete();
  endtask

  typedef struct {
    int sq, tr, st, ab, rdy, sd;
    int vld, dx, dy, pen, bsy, id, dn;
  } vec_t;
  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d;
    //        sq tr st ab rdy sd | vld   dx    dy pen bsy id dn
    tbl[0]  = '{0, 1, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 1, 2, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 0,  1,  400,    0, 1, 1, 2, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1,  0,    0,    0, 1, 1, 2, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 0,  1, -200,  400, 1, 1, 2, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 1, 1, 2, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1,  0,    0,    0, 1, 1, 2, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1,  1, -200, -400, 1, 1, 2, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 0,  1, -200, -400, 1, 1, 2, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1,  0,    0,    0, 1, 1, 2, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 1, 1, 2, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 0,  0,    0,    0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};

    reset = 1'b0; req_square = 1'b0; req_tri = 1'b0; req_star = 1'b0; abort = 1'b0;
    tb_ready = 1'b0; tb_sd = 1'b0; auto_dp = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_dx", int'(cmd_dx), 0);
    chk("rst_dy", int'(cmd_dy), 0);
    chk("rst_pen", int'(pen_down), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(shape_id), 0);
    chk("rst_done", int'(shape_done), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      req_square = tbl[i].sq[0]; req_tri = tbl[i].tr[0]; req_star = tbl[i].st[0];
      abort = tbl[i].ab[0]; tb_ready = tbl[i].rdy[0]; tb_sd = tbl[i].sd[0];
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), int'(cmd_valid), tbl[i].vld);
      chk($sformatf("vec%0d_dx", i), int'($signed(cmd_dx)), tbl[i].dx);
      chk($sformatf("vec%0d_dy", i), int'($signed(cmd_dy)), tbl[i].dy);
      chk($sformatf("vec%0d_pen", i), int'(pen_down), tbl[i].pen);
      chk($sformatf("vec%0d_busy", i), int'(busy), tbl[i].bsy);
      chk($sformatf("vec%0d_id", i), int'(shape_id), tbl[i].id);
      chk($sformatf("vec%0d_done", i), int'(shape_done), tbl[i].dn);
      @(posedge clk);
      #1;
    end
    req_square = 1'b0; req_tri = 1'b0; req_star = 1'b0; abort = 1'b0; tb_sd = 1'b0;
    auto_dp = 1'b1; tb_ready = 1'b1;

    // Single square.
    b = got.size(); d = done_cnt;
    pulse(1, 0, 0);
    repeat (2) tick();
    wait_quiet("sq", 300);
    add(400, 0, 1); add(0, 400, 1); add(-400, 0, 1); add(0, -400, 1);
    compare_log("sq", b);
    chk("sq_done_count", done_cnt - d, 1);
    chk("sq_pen_after", int'(pen_down), 0);

    // Simultaneous square + star: square wins, star follows.
    b = got.size(); d = done_cnt;
    pulse(1, 0, 1);
    repeat (2) tick();
    wait_quiet("sqstar", 500);
    add(400, 0, 1); add(0, 400, 1); add(-400, 0, 1); add(0, -400, 1);
    add(200, 400, 3); add(200, -400, 3); add(-400, 200, 3); add(400, 0, 3); add(-400, -200, 3);
    compare_log("sqstar", b);
    chk("sqstar_done_count", done_cnt - d, 2);

    // Back-pressure: command held stable while cmd_ready is low.
    b = got.size(); d = done_cnt;
    tb_ready = 1'b0;
    pulse(0, 1, 0);
    for (int n = 0; n < 10 && !cmd_valid; n++) tick();
    chk("bp_valid_rise", int'(cmd_valid), 1);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", n), int'(cmd_valid), 1);
      chk($sformatf("bp_hold%0d_dx", n), int'($signed(cmd_dx)), 400);
      chk($sformatf("bp_hold%0d_dy", n), int'($signed(cmd_dy)), 0);
    end
    chk("bp_no_hs_yet", got.size() - b, 0);
    tb_ready = 1'b1;
    repeat (2) tick();
    chk("bp_one_hs", got.size() - b, 1);
    wait_quiet("bp", 300);
    add(400, 0, 2); add(-200, 400, 2); add(-200, -400, 2);
    compare_log("bp", b);
    chk("bp_done_count", done_cnt - d, 1);

    // Repeated triangle requests mid-square collapse to one triangle.
    b = got.size(); d = done_cnt;
    pulse(1, 0, 0);
    repeat (6) tick();
    pulse(0, 1, 0);
    repeat (6) tick();
    pulse(0, 1, 0);
    wait_quiet("rep", 500);
    add(400, 0, 1); add(0, 400, 1); add(-400, 0, 1); add(0, -400, 1);
    add(400, 0, 2); add(-200, 400, 2); add(-200, -400, 2);
    compare_log("rep", b);
    chk("rep_done_count", done_cnt - d, 2);

    // Abort in WAIT of the second star segment, with a request in the abort cycle.
    b = got.size(); d = done_cnt;
    pulse(0, 0, 1);
    wait_hs("ab", b + 2, 100);
    abort = 1'b1; req_square = 1'b1;
    tick();
    abort = 1'b0; req_square = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_pen", int'(pen_down), 0);
    chk("ab_valid", int'(cmd_valid), 0);
    chk("ab_id", int'(shape_id), 0);
    repeat (10) tick();
    chk("ab_still_idle", int'(busy), 0);
    chk("ab_no_done", done_cnt - d, 0);
    add(200, 400, 3); add(200, -400, 3);
    compare_log("ab", b);

    // Reset mid-triangle with a square pending.
    b = got.size(); d = done_cnt;
    pulse(0, 1, 0);
    wait_hs("rs", b + 1, 100);
    tb_ready = 1'b0;
    pulse(1, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rs_valid", int'(cmd_valid), 0);
    chk("rs_dx", int'(cmd_dx), 0);
    chk("rs_dy", int'(cmd_dy), 0);
    chk("rs_pen", int'(pen_down), 0);
    chk("rs_busy", int'(busy), 0);
    chk("rs_id", int'(shape_id), 0);
    tb_ready = 1'b1;
    repeat (10) tick();
    chk("rs_no_activity", int'(busy), 0);
    chk("rs_no_moves", got.size() - b, 1);
    chk("rs_no_done", done_cnt - d, 0);
    pulse(1, 0, 0);
    repeat (2) tick();
    wait_quiet("rs_new", 300);
    add(400, 0, 2);
    add(400, 0, 1); add(0, 400, 1); add(-400, 0, 1); add(0, -400, 1);
    compare_log("rs", b);
    chk("rs_done_count", done_cnt - d, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
